// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - TD4 16x8 program memory with UART frame loader; PROG_LOADER_DEFAULT_PROG_EN selects the demo reset image
module prog_loader #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic [3:0] address,
  output logic [7:0] data,
  output logic       cpu_reset,
  output logic       loading,
  output logic       load_error
);

  localparam int CPB    = CLK_HZ / BAUD;
  localparam int CNT_W  = $clog2(CPB);
  localparam int TO_CYC = TIMEOUT_BITS * CPB;
  localparam int TO_W   = $clog2(TO_CYC + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;
  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_CHECK, LD_COMMIT} ld_state_e;

  // UART receiver state
  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;

  // Loader state
  ld_state_e        ld_state_q, ld_state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             load_error_q, load_error_d;
  logic             cpu_reset_q, loading_q;
  logic             shadow_we, commit;
  logic [7:0]       shadow_q [16];
  logic [7:0]       active_q [16];

  // Two-flop synchronizer plus a third flop so a falling edge can be seen
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // Receiver next state: mid-bit sampling, glitch reject on start, break wait after bad stop
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_s3_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_valid_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_d  = 1'b1;
            rx_state_d = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        rx_cnt_d = '0;
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // Loader next state: sync, 16 image bytes, checksum, then a one-cycle commit
  always_comb begin
    ld_state_d   = ld_state_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    to_cnt_d     = to_cnt_q + 1'b1;
    load_error_d = load_error_q;
    shadow_we    = 1'b0;
    commit       = 1'b0;
    case (ld_state_q)
      LD_IDLE: begin
        to_cnt_d = '0;
        if (rx_valid_q && rx_shift_q == 8'h55) begin
          load_error_d = 1'b0;
          idx_d        = '0;
          sum_d        = '0;
          ld_state_d   = LD_LOAD;
        end
      end
      LD_LOAD: begin
        if (rx_ferr_q || to_cnt_q == TO_LAST) begin
          load_error_d = 1'b1;
          ld_state_d   = LD_IDLE;
        end else if (rx_valid_q) begin
          shadow_we = 1'b1;
          sum_d     = sum_q + rx_shift_q;
          idx_d     = idx_q + 1'b1;
          to_cnt_d  = '0;
          if (idx_q == 4'd15) ld_state_d = LD_CHECK;
        end
      end
      LD_CHECK: begin
        if (rx_ferr_q || to_cnt_q == TO_LAST) begin
          load_error_d = 1'b1;
          ld_state_d   = LD_IDLE;
        end else if (rx_valid_q) begin
          if (rx_shift_q == sum_q) begin
            ld_state_d = LD_COMMIT;
          end else begin
            load_error_d = 1'b1;
            ld_state_d   = LD_IDLE;
          end
        end
      end
      LD_COMMIT: begin
        commit     = 1'b1;
        ld_state_d = LD_IDLE;
      end
      default: ld_state_d = LD_IDLE;
    endcase
  end

  // Loader registers; CPU reset and loading flag follow the next state so they align with it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_state_q   <= LD_IDLE;
      idx_q        <= '0;
      sum_q        <= '0;
      to_cnt_q     <= '0;
      load_error_q <= 1'b0;
      cpu_reset_q  <= 1'b0;
      loading_q    <= 1'b0;
    end else begin
      ld_state_q   <= ld_state_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      to_cnt_q     <= to_cnt_d;
      load_error_q <= load_error_d;
      cpu_reset_q  <= (ld_state_d != LD_IDLE);
      loading_q    <= (ld_state_d != LD_IDLE);
    end
  end

  // Shadow image collects the frame without disturbing the running program
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) shadow_q[i] <= 8'h00;
    end else if (shadow_we) begin
      shadow_q[idx_q] <= rx_shift_q;
    end
  end

  // Active image: reset image, replaced all at once on commit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) active_q[i] <= 8'h00;
`ifdef PROG_LOADER_DEFAULT_PROG_EN
      active_q[0] <= 8'hB1;
      active_q[1] <= 8'hB2;
      active_q[2] <= 8'hB4;
      active_q[3] <= 8'hB8;
      active_q[4] <= 8'hF0;
`else
`endif
    end else if (commit) begin
      for (int i = 0; i < 16; i++) active_q[i] <= shadow_q[i];
    end
  end

  assign data       = active_q[address];
  assign cpu_reset  = cpu_reset_q;
  assign loading    = loading_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader with randomized frames
module tb_prog_loader;

  localparam int CPB   = 16;
  localparam int BIT_T = CPB * 100;

`ifdef PROG_LOADER_DEFAULT_PROG_EN
  localparam logic [127:0] RESET_IMG = {88'h0, 8'hF0, 8'hB8, 8'hB4, 8'hB2, 8'hB1};
`else
  localparam logic [127:0] RESET_IMG = 128'h0;
`endif

  typedef struct packed {
    logic         is_reset;
    logic         err;
    logic [127:0] img;
    int           lat;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       uart_rx;
  logic [3:0] address = 4'd0;
  logic [7:0] data;
  logic       cpu_reset, loading, load_error;

  exp_t         sb[$];
  logic [127:0] ref_active;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           last_rv = 0;
  int           rv_count = 0;
  logic         prev_reset = 1'b1;
  logic         prev_cr = 1'b0;

  prog_loader #(.CLK_HZ(CPB * 100_000), .BAUD(100_000), .TIMEOUT_BITS(32)) dut (
    .clock(clk), .reset(reset), .uart_rx(uart_rx), .address(address),
    .data(data), .cpu_reset(cpu_reset), .loading(loading), .load_error(load_error)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_mem(input string tag, input logic [127:0] img);
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      chk($sformatf("%s mem[%0d]", tag, a), int'(data), int'(img[a*8 +: 8]));
      #1;
    end
  endtask

  // Monitor: pops expectations at reset release and at each fall of cpu_reset
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (dut.rx_valid_q) begin
      last_rv = cyc;
      rv_count++;
    end
    if (!reset) begin
      if (prev_reset) begin
        chk("async cpu_reset", int'(cpu_reset), 0);
        chk("async loading", int'(loading), 0);
        chk("async load_error", int'(load_error), 0);
      end
      prev_cr = 1'b0;
    end else if (!prev_reset) begin
      if (sb.size() == 0) begin
        chk("reset sb entry present", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("reset entry kind", int'(e.is_reset), 1);
        chk("reset cpu_reset", int'(cpu_reset), 0);
        chk("reset loading", int'(loading), 0);
        chk("reset load_error", int'(load_error), 0);
        chk_mem("reset", e.img);
      end
    end else begin
      if (cpu_reset && !prev_cr) begin
        chk("cpu_reset rise latency", cyc - last_rv, 1);
        chk("loading with cpu_reset", int'(loading), 1);
      end
      if (!cpu_reset && prev_cr) begin
        if (sb.size() == 0) begin
          chk("frame sb entry present", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("frame entry kind", int'(e.is_reset), 0);
          chk("frame load_error", int'(load_error), int'(e.err));
          chk("loading released", int'(loading), 0);
          if (e.lat >= 0) chk("release latency", cyc - last_rv, e.lat);
          chk_mem("frame", e.img);
        end
      end
      prev_cr = cpu_reset;
    end
    prev_reset = reset;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    #BIT_T;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      #BIT_T;
    end
    uart_rx = stop;
    #BIT_T;
    uart_rx = 1'b1;
  endtask

  function automatic logic [7:0] img_sum(input logic [127:0] img);
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(img[i*8 +: 8]);
    return 8'(s % 256);
  endfunction

  task automatic send_frame(input logic [127:0] img, input logic [7:0] cs, input int gap_max);
    exp_t e;
    logic good;
    good       = (cs == img_sum(img));
    e.is_reset = 1'b0;
    e.err      = !good;
    e.img      = good ? img : ref_active;
    e.lat      = good ? 2 : 1;
    sb.push_back(e);
    if (good) ref_active = img;
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (gap_max > 0) #(BIT_T * $urandom_range(0, gap_max));
      send_byte(img[i*8 +: 8], 1'b1);
    end
    send_byte(cs, 1'b1);
    #(BIT_T * 2);
  endtask

  task automatic push_abort();
    exp_t e;
    e.is_reset = 1'b0;
    e.err      = 1'b1;
    e.img      = ref_active;
    e.lat      = -1;
    sb.push_back(e);
  endtask

  task automatic push_reset();
    exp_t e;
    e.is_reset = 1'b1;
    e.err      = 1'b0;
    e.img      = RESET_IMG;
    e.lat      = -1;
    sb.push_back(e);
    ref_active = RESET_IMG;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      #100;
      n++;
    end
    if (sb.size() != 0) chk({name, " drain timeout"}, sb.size(), 0);
  endtask

  function automatic logic [127:0] rand_img();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  initial begin
    logic [127:0] seq_img;
    logic [127:0] img;
    logic [7:0]   cs;
    int           rv_before;

    reset   = 1'b1;
    uart_rx = 1'b1;
    push_reset();
    #1 reset = 1'b0;
    #332 reset = 1'b1;
    #(BIT_T * 2);

    for (int i = 0; i < 16; i++) seq_img[i*8 +: 8] = 8'(i);
    send_frame(seq_img, 8'h78, 0);
    wait_drain("good frame");
    address = 4'd7;
    #1 chk("addr7 after load", int'(data), 8'h07);

    send_frame(seq_img, 8'h77, 0);
    wait_drain("bad checksum");

    img = rand_img();
    send_frame(img, img_sum(img), 0);
    wait_drain("good after bad");

    push_abort();
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    #(BIT_T * 33);
    wait_drain("timeout");

    push_abort();
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    send_byte(8'hA5, 1'b0);
    uart_rx = 1'b0;
    #(BIT_T * 3);
    uart_rx = 1'b1;
    #(BIT_T * 2);
    wait_drain("framing");

    rv_before = rv_count;
    uart_rx = 1'b0;
    #(BIT_T / 4);
    uart_rx = 1'b1;
    #(BIT_T * 3);
    chk("glitch no rx_valid", rv_count, rv_before);

    for (int k = 0; k < 5; k++) begin
      img = rand_img();
      cs  = img_sum(img);
      if ($urandom_range(0, 2) == 0) cs = cs + 8'($urandom_range(1, 255));
      send_frame(img, cs, 3);
      wait_drain("random frame");
    end

    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    uart_rx = 1'b0;
    #BIT_T;
    for (int i = 0; i < 4; i++) begin
      uart_rx = 1'($urandom_range(0, 1));
      #BIT_T;
    end
    push_reset();
    reset = 1'b0;
    #1 chk("cpu_reset cleared immediately", int'(cpu_reset), 0);
    uart_rx = 1'b1;
    #(BIT_T * 2);
    reset = 1'b1;
    #(BIT_T * 2);
    wait_drain("mid-frame reset");

    img = rand_img();
    send_frame(img, img_sum(img), 1);
    wait_drain("fresh frame");

    chk("scoreboard empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory block that feeds the TD4 CPU core: holds the 16×8 instruction store and answers the CPU's 4-bit `address` with an 8-bit `data` word combinationally. A built-in UART receiver accepts a framed 16-byte program image. The CPU is held in reset while a frame is in progress. A verified image is committed atomically, so the CPU restarts at address 0 on the new program.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115_200: UART bit rate. Derived `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division, must be ≥ 4).
- `TIMEOUT_BITS`, 32: maximum idle gap between bytes inside a frame, in bit periods.

- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `uart_rx`  in  1  serial input, 8N1, idle high; asynchronous to `clock`.
- `address`  in  4  CPU fetch address.
- `data`  out  8  instruction at `address`.
- `cpu_reset`  out  1  active-high reset to the CPU; high while a frame is being loaded.
- `loading`  out  1  high in any non-IDLE loader state.
- `load_error`  out  1  sticky; set on a failed frame.

## Operation
- **Reset values:**
  - Active memory: see Configuration.
  - Shadow memory, checksum, counters: 0.
  - FSM: IDLE.
  - `cpu_reset`, `loading`, `load_error`: 0.
- **Read path:** `data = active[address]`, purely combinational, no latency.
- **UART RX:**
  - `uart_rx` passes through a 2-flop synchronizer, with a third flop for edge detection.
  - A falling edge while the receiver is idle starts a byte.
  - Start bit is re-checked at `CLKS_PER_BIT/2`; if it is high, the event is a glitch and is discarded.
  - Data bits are sampled every `CLKS_PER_BIT` thereafter, LSB first. The stop bit is sampled likewise.
  - Stop = 1: one-cycle `rx_valid` pulse with the byte.
  - Stop = 0: `rx_ferr` pulse, then the receiver waits for the line to be high before arming again (break handling).
- **Frame format:** sync `0x55`, then 16 image bytes for addresses 0..15, then a checksum equal to the sum of the 16 bytes mod 256.
- **Loader FSM:**
  - IDLE: on `rx_valid` with byte `0x55`, clear `load_error`, zero the index and sum, go to LOAD. Other bytes and framing errors are ignored.
  - LOAD: on each `rx_valid`, write `shadow[idx]`, add the byte to the sum, increment idx. After the byte with idx = 15, go to CHECK. `0x55` here is ordinary data.
  - CHECK: on `rx_valid`, match goes to COMMIT; mismatch sets `load_error` and goes to IDLE.
  - COMMIT: lasts one cycle. All 16 active entries are loaded from shadow on this edge, then the FSM goes to IDLE.
  - Abort from LOAD or CHECK goes to IDLE with `load_error = 1` and active memory unchanged. Causes:
    - `rx_ferr`;
    - no byte completed for `TIMEOUT_BITS × CLKS_PER_BIT` cycles, counted from the last `rx_valid`.
- **Output flags:**
  - `cpu_reset` and `loading` are registered, high in LOAD, CHECK and COMMIT.
  - On an aborted or bad frame the CPU is released onto the unchanged old program, restarting from ip = 0.

## Timing
- The sync-byte `rx_valid` is on cycle N. `cpu_reset` and `loading` are high from cycle N+1.
- The checksum `rx_valid` is on cycle M. COMMIT occupies cycle M+1.
- On a good frame, new `data` is visible from cycle M+2, and `cpu_reset` falls in the same cycle M+2.
- On a bad checksum, `load_error` and the fall of `cpu_reset` both occur at cycle M+1.
- `rx_valid` falls at mid-stop-bit, about 9.5 bit periods after the start edge.
- Asserting `reset` mid-frame forces all state to reset values immediately and discards the partial shadow. Active memory returns to its reset image.

## Configuration
- `PROG_LOADER_DEFAULT_PROG_EN` defined: active memory resets to a demo LED-chase program. Addresses 0..4 are `0xB1 0xB2 0xB4 0xB8 0xF0` (out 1/2/4/8, jmp 0); addresses 5..15 are `0x00`.
- Undefined: active memory resets to all `0x00`.

## Test plan
- After reset with the macro defined, `address` 0..4 gives `data` `B1 B2 B4 B8 F0` and `address` 9 gives `00`. With the macro undefined, every address reads `00`. In both cases `cpu_reset = 0`.
- Send a valid frame: `55`, then bytes `00..0F`, then checksum `78`.
  - `cpu_reset` rises one cycle after the sync `rx_valid`.
  - Two cycles after the checksum `rx_valid`, `address` 7 reads `07`, `cpu_reset = 0` and `load_error = 0`.
- Send the same frame with checksum `77`. Then `load_error = 1`, active memory is unchanged and `cpu_reset` is released. A following good frame clears `load_error`.
- Send the sync plus 5 bytes, then leave the line idle for 33 bit periods. The loader aborts to IDLE with `load_error = 1` and memory unchanged.
- Send a byte with its stop bit forced to 0 mid-frame. A framing abort sets `load_error = 1`, and the line is held low as a break until it returns high. A 1/4-bit low glitch on an idle line produces no `rx_valid`.
- Assert `reset` (low) during byte 10 of a frame. Outputs clear asynchronously, memory returns to its reset image, and a fresh full frame afterwards loads correctly.
